// File: rtl/reg_file_sb_pkg.sv
// Shared parameters and helpers for the scoreboarded register file.
// Imported by reg_file_sb and reg_word.
package reg_file_sb_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_DEPTH   = 8;
  localparam bit DEF_ZERO_R0 = 1'b1;
  localparam bit DEF_BYPASS  = 1'b1;

  // Index width for a register file of the given depth; never below 1.
  function automatic int addr_bits(input int depth);
    int n;
    n = 0;
    while ((1 << n) < depth) n++;
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/reg_file_sb_reg_word.sv
// One architectural register: WIDTH-bit load-enable flop
// with asynchronous active-high clear.
module reg_word
  import reg_file_sb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Two-read one-write register file with write-back bypass
// and a per-register pending (busy) scoreboard.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int   WIDTH   = DEF_WIDTH,
  parameter int   DEPTH   = DEF_DEPTH,
  parameter bit   ZERO_R0 = DEF_ZERO_R0,
  parameter bit   BYPASS  = DEF_BYPASS,
  localparam int  AW      = addr_bits(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  output logic             busy_a,
  output logic             busy_b
);

  logic [WIDTH-1:0] word [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    localparam logic [AW-1:0] IDX   = AW'(i);
    localparam bit            HARD0 = ZERO_R0 && (i == 0);
    logic en;
    assign en = we && (waddr == IDX) && !HARD0;
    reg_word #(
      .WIDTH (WIDTH)
    ) u_word (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .d   (wdata),
      .q   (word[i])
    );
  end

  // Issue is applied after write-back so a new producer wins.
  always_comb begin
    busy_nxt = busy;
    if (we) begin
      busy_nxt[waddr] = 1'b0;
    end
    if (iss_en && !(ZERO_R0 && (iss_addr == '0))) begin
      busy_nxt[iss_addr] = 1'b1;
    end
    if (ZERO_R0) begin
      busy_nxt[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  logic hit_a;
  logic hit_b;
  logic zero_a;
  logic zero_b;

  assign hit_a  = BYPASS && we && !rst
                  && (waddr == raddr_a);
  assign hit_b  = BYPASS && we && !rst
                  && (waddr == raddr_b);
  assign zero_a = ZERO_R0 && (raddr_a == '0);
  assign zero_b = ZERO_R0 && (raddr_b == '0);

  assign rdata_a = zero_a ? '0
                 : hit_a  ? wdata
                 : word[raddr_a];
  assign rdata_b = zero_b ? '0
                 : hit_b  ? wdata
                 : word[raddr_b];

  assign busy_a = hit_a ? 1'b0 : busy[raddr_a];
  assign busy_b = hit_b ? 1'b0 : busy[raddr_b];

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: reference model feeds
// an expectation queue; directed scenarios add literal checks.
module tb_reg_file_sb;

  logic        clk;
  logic        rst;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic [2:0]  raddr_a;
  logic [2:0]  raddr_b;
  logic [15:0] rdata_a;
  logic [15:0] rdata_b;
  logic        iss_en;
  logic [2:0]  iss_addr;
  logic        busy_a;
  logic        busy_b;

  int errors = 0;
  int checks = 0;

  reg_file_sb dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr_a  (raddr_a),
    .raddr_b  (raddr_b),
    .rdata_a  (rdata_a),
    .rdata_b  (rdata_b),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_a   (busy_a),
    .busy_b   (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state
  logic [15:0] mem [8];
  logic        mb  [8];

  typedef struct {
    string       tag;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        ba;
    logic        bb;
  } exp_t;

  exp_t sb[$];

  function automatic logic [15:0] mrd(input logic [2:0] a);
    if (rst) return 16'h0;
    if (a == 3'd0) return 16'h0;
    if (we && waddr == a) return wdata;
    return mem[a];
  endfunction

  function automatic logic mbz(input logic [2:0] a);
    if (rst) return 1'b0;
    if (we && waddr == a) return 1'b0;
    return mb[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      mem[i] = 16'h0;
      mb[i]  = 1'b0;
    end
  endtask

  task automatic idle();
    we       = 1'b0;
    iss_en   = 1'b0;
    waddr    = 3'd0;
    wdata    = 16'h0;
    iss_addr = 3'd0;
  endtask

  // Push expectation, sample mid-cycle, compare, then clock the model.
  task automatic step(input string tag);
    exp_t e;
    exp_t g;
    e.tag = tag;
    e.ra  = mrd(raddr_a);
    e.rb  = mrd(raddr_b);
    e.ba  = mbz(raddr_a);
    e.bb  = mbz(raddr_b);
    sb.push_back(e);
    #1;
    g = sb.pop_front();
    checks++;
    if (rdata_a !== g.ra) begin
      errors++;
      $display("FAIL %s rdata_a got %h exp %h", g.tag, rdata_a, g.ra);
    end
    checks++;
    if (rdata_b !== g.rb) begin
      errors++;
      $display("FAIL %s rdata_b got %h exp %h", g.tag, rdata_b, g.rb);
    end
    checks++;
    if (busy_a !== g.ba) begin
      errors++;
      $display("FAIL %s busy_a got %b exp %b", g.tag, busy_a, g.ba);
    end
    checks++;
    if (busy_b !== g.bb) begin
      errors++;
      $display("FAIL %s busy_b got %b exp %b", g.tag, busy_b, g.bb);
    end
    @(posedge clk);
    #1;
    if (!rst) begin
      if (we && waddr != 3'd0) mem[waddr] = wdata;
      if (we) mb[waddr] = 1'b0;
      if (iss_en && iss_addr != 3'd0) mb[iss_addr] = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    raddr_a = 3'd0;
    raddr_b = 3'd0;
    model_clear();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      raddr_a = 3'(i);
      raddr_b = 3'(7 - i);
      #1;
      checks++;
      if (rdata_a !== 16'h0 || busy_a !== 1'b0) begin
        errors++;
        $display("FAIL reset_rd got %h/%b exp 0000/0", rdata_a, busy_a);
      end
      step("reset");
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      raddr_a = 3'(i);
      raddr_b = 3'(i);
      step("post_reset");
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    we = 1'b1; waddr = 3'd3; wdata = 16'hBEEF;
    raddr_a = 3'd3; raddr_b = 3'd1;
    #1;
    checks++;
    if (rdata_a !== 16'hBEEF) begin
      errors++;
      $display("FAIL bypass_same got %h exp beef", rdata_a);
    end
    step("bypass_wr");
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (rdata_a !== 16'hBEEF) begin
      errors++;
      $display("FAIL bypass_held got %h exp beef", rdata_a);
    end
    step("bypass_held");
  endtask

  task automatic test_zero();
    @(negedge clk);
    we = 1'b1; waddr = 3'd0; wdata = 16'h1234;
    raddr_b = 3'd0;
    #1;
    checks++;
    if (rdata_b !== 16'h0) begin
      errors++;
      $display("FAIL r0_same got %h exp 0000", rdata_b);
    end
    step("r0_wr");
    @(negedge clk);
    idle();
    iss_en = 1'b1; iss_addr = 3'd0;
    step("r0_iss");
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (rdata_b !== 16'h0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL r0_after got %h/%b exp 0000/0", rdata_b, busy_b);
    end
    step("r0_after");
  endtask

  task automatic test_busy();
    @(negedge clk);
    idle();
    iss_en = 1'b1; iss_addr = 3'd5;
    step("busy_iss");
    @(negedge clk);
    idle();
    raddr_a = 3'd5;
    #1;
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL busy_set got %b exp 1", busy_a);
    end
    step("busy_set");
    @(negedge clk);
    we = 1'b1; waddr = 3'd5; wdata = 16'h00A5;
    #1;
    checks++;
    if (busy_a !== 1'b0 || rdata_a !== 16'h00A5) begin
      errors++;
      $display("FAIL busy_wb got %b/%h exp 0/00a5", busy_a, rdata_a);
    end
    step("busy_wb");
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL busy_clr got %b exp 0", busy_a);
    end
    step("busy_clr");
  endtask

  task automatic test_same_edge();
    @(negedge clk);
    iss_en = 1'b1; iss_addr = 3'd2;
    we = 1'b1; waddr = 3'd2; wdata = 16'h0F0F;
    raddr_a = 3'd2; raddr_b = 3'd4;
    step("same_edge");
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (rdata_a !== 16'h0F0F || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL same_edge got %h/%b exp 0f0f/1", rdata_a, busy_a);
    end
    step("same_after");
    // Different indices, plus repeated issue to a busy register
    @(negedge clk);
    iss_en = 1'b1; iss_addr = 3'd4;
    we = 1'b1; waddr = 3'd2; wdata = 16'h2222;
    step("diff_idx");
    @(negedge clk);
    idle();
    iss_en = 1'b1; iss_addr = 3'd4;
    step("reissue");
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b1) begin
      errors++;
      $display("FAIL diff_idx got %b/%b exp 0/1", busy_a, busy_b);
    end
    we = 1'b1; waddr = 3'd4; wdata = 16'h4444;
    step("wb4");
    @(negedge clk);
    idle();
    step("wb4_after");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    we = 1'b1; waddr = 3'd6; wdata = 16'h7777;
    step("w6");
    @(negedge clk);
    idle();
    iss_en = 1'b1; iss_addr = 3'd6;
    step("i6");
    @(negedge clk);
    idle();
    raddr_a = 3'd6; raddr_b = 3'd6;
    #1;
    checks++;
    if (rdata_a !== 16'h7777 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst got %h/%b exp 7777/1", rdata_a, busy_a);
    end
    rst = 1'b1;
    model_clear();
    #1;
    checks++;
    if (rdata_a !== 16'h0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL async_rst got %h/%b exp 0000/0", rdata_a, busy_b);
    end
    // Write and issue presented while reset is held are discarded.
    we = 1'b1; waddr = 3'd6; wdata = 16'h5555;
    iss_en = 1'b1; iss_addr = 3'd6;
    step("in_rst");
    @(negedge clk);
    idle();
    rst = 1'b0;
    #1;
    checks++;
    if (rdata_a !== 16'h0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL rst_discard got %h/%b exp 0000/0", rdata_a, busy_a);
    end
    step("after_rst");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      we       = 1'($urandom_range(1, 0));
      waddr    = 3'($urandom_range(7, 0));
      wdata    = 16'($urandom);
      iss_en   = 1'($urandom_range(1, 0));
      iss_addr = 3'($urandom_range(7, 0));
      raddr_a  = 3'($urandom_range(7, 0));
      raddr_b  = (n % 3 == 0) ? waddr : 3'($urandom_range(7, 0));
      step("rand");
    end
    @(negedge clk);
    idle();
    step("rand_end");
  endtask

  initial begin
    rst = 1'b1;
    idle();
    raddr_a = 3'd0;
    raddr_b = 3'd0;
    model_clear();
    test_reset();
    test_bypass();
    test_zero();
    test_busy();
    test_same_edge();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter WIDTH, default 16, data bits per register.
REQ-002 Parameter DEPTH, default 8, number of registers (power of two, >=2); AW = clog2(DEPTH).
REQ-003 Parameter ZERO_R0, default 1, when 1 register 0 reads zero and ignores writes and issues.
REQ-004 Parameter BYPASS, default 1, when 1 same-cycle write data is forwarded to read ports.
REQ-005 Port clk, input, 1, clock; all state updates on rising edge.
REQ-006 Port rst, input, 1, reset, asynchronous, active-high.
REQ-007 Port we, input, 1, write-back enable.
REQ-008 Port waddr, input, AW, write-back register index.
REQ-009 Port wdata, input, WIDTH, write-back data.
REQ-010 Port raddr_a / raddr_b, input, AW each, read indices.
REQ-011 Port rdata_a / rdata_b, output, WIDTH each, read data.
REQ-012 Port iss_en, input, 1, instruction issue; marks destination pending.
REQ-013 Port iss_addr, input, AW, issued destination index.
REQ-014 Port busy_a / busy_b, output, 1 each, read operand still pending.

Function
REQ-015 Storage SHALL be DEPTH words of WIDTH bits; word i updates to wdata on clk edge iff we=1, waddr=i, and not (ZERO_R0=1 and i=0); otherwise holds.
REQ-016 Reads SHALL be combinational, zero-latency: rdata_x = word[raddr_x].
REQ-017 With BYPASS=1, if we=1 and waddr=raddr_x, rdata_x SHALL equal wdata in that same cycle; with BYPASS=0, old word value.
REQ-018 With ZERO_R0=1, raddr_x=0 SHALL give rdata_x=0 regardless of we/wdata/bypass.
REQ-019 Scoreboard: one busy bit per register; iss_en=1 SHALL set busy[iss_addr] at next edge; we=1 SHALL clear busy[waddr] at next edge.
REQ-020 Simultaneous iss_en and we to the same index SHALL leave busy=1 (new producer wins) while data is still written.
REQ-021 Simultaneous iss_en and we to different indices SHALL apply both.
REQ-022 With ZERO_R0=1, issue to index 0 SHALL be ignored; busy[0] is constant 0.
REQ-023 busy_x = busy[raddr_x], except with BYPASS=1 and we=1 and waddr=raddr_x, busy_x SHALL be 0 that cycle.
REQ-024 A write to a non-busy register SHALL be accepted normally (no error flag).
REQ-025 Repeated issue to an already-busy index SHALL keep busy=1; single write-back clears it.

Reset
REQ-026 rst=1 SHALL asynchronously clear all words and busy bits, independent of clk.
REQ-027 During and immediately after reset rdata_a=rdata_b=0 and busy_a=busy_b=0 (bypass still applies if we=1 with rst released).
REQ-028 Reset asserted mid-operation SHALL discard any same-edge write or issue.

Structure
REQ-029 Shared package SHALL hold default WIDTH/DEPTH, ZERO_R0/BYPASS defaults, and the AW derivation function.
REQ-030 One sub-module reg_word SHALL implement a WIDTH-bit enable register with async reset; instantiated DEPTH times.
REQ-031 Scoreboard, bypass muxes and read muxes SHALL live in reg_file_sb.

Verification
REQ-032 Reset then read all indices -> every rdata 0, busy 0.
REQ-033 we=1 waddr=3 wdata=16'hBEEF, raddr_a=3 same cycle -> rdata_a=BEEF that cycle (BYPASS=1); next cycle, we=0 -> still BEEF.
REQ-034 we=1 waddr=0 wdata=16'h1234, raddr_b=0 -> rdata_b=0 same and following cycles; iss_en addr 0 -> busy_b stays 0.
REQ-035 iss_en addr 5; next cycle raddr_a=5 -> busy_a=1; we addr 5 wdata=16'h00A5 -> busy_a=0 same cycle, rdata_a=00A5; busy bit clear after edge.
REQ-036 Same edge iss_en addr 2 and we addr 2 wdata=16'h0F0F -> word2=0F0F, busy[2]=1 afterwards.
REQ-037 Write word6=16'h7777, issue addr 6, assert rst between edges -> rdata 0 and busy 0 immediately, before next clk.
